// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer:
// opcodes, R-type funct codes, ALU control codes and FSM states.
package mips_ctrl_pkg;

  localparam logic [5:0] RTYPE = 6'h00;
  localparam logic [5:0] ADDI  = 6'h08;
  localparam logic [5:0] SLTI  = 6'h0A;
  localparam logic [5:0] LW    = 6'h23;
  localparam logic [5:0] SW    = 6'h2B;

  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_NOR = 6'h27;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4
  } state_t;

endpackage

// File: rtl/mips_alu_ctrl_decode.sv
// Combinational instruction classifier: opcode/funct to datapath controls
// plus flags telling the sequencer which path the instruction takes.
module mips_alu_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] ALUCtrl,
  output logic       RegDst,
  output logic       ALUSrc,
  output logic       MemtoReg,
  output logic       isMem,
  output logic       isStore,
  output logic       legal
);

  always_comb begin
    ALUCtrl  = '0;
    RegDst   = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    isMem    = 1'b0;
    isStore  = 1'b0;
    legal    = 1'b1;
    unique case (opcode)
      RTYPE: begin
        unique case (funct)
          FN_AND:  ALUCtrl = ALU_AND;
          FN_OR:   ALUCtrl = ALU_OR;
          FN_ADD:  ALUCtrl = ALU_ADD;
          FN_SUB:  ALUCtrl = ALU_SUB;
          FN_SLT:  ALUCtrl = ALU_SLT;
          FN_NOR:  ALUCtrl = ALU_NOR;
          default: legal   = 1'b0;
        endcase
      end
      ADDI: begin
        ALUCtrl = ALU_ADD;
        RegDst  = 1'b1;
        ALUSrc  = 1'b1;
      end
      SLTI: begin
        ALUCtrl = ALU_SLT;
        RegDst  = 1'b1;
        ALUSrc  = 1'b1;
      end
      LW: begin
        ALUCtrl  = ALU_ADD;
        RegDst   = 1'b1;
        ALUSrc   = 1'b1;
        MemtoReg = 1'b1;
        isMem    = 1'b1;
      end
      SW: begin
        ALUCtrl = ALU_ADD;
        RegDst  = 1'b1;
        ALUSrc  = 1'b1;
        isMem   = 1'b1;
        isStore = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle control sequencer for the single-cycle MIPS datapath: accepts one
// instruction per handshake and steps it through DECODE/EXECUTE/MEM/WRITEBACK.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   instrValid,
  input  logic [31:0]            instruction,
  output logic                   instrReady,
  output logic [31:0]            instrOut,
  output logic                   RegDst,
  output logic                   ALUSrc,
  output logic [3:0]             ALUCtrl,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   MemtoReg,
  output logic                   RegWrite,
  output logic                   illegal,
  output logic [COUNT_WIDTH-1:0] retiredCount
);

  state_t state, next;

  logic [3:0] dec_alu;
  logic       dec_regdst, dec_alusrc, dec_memtoreg;
  logic       dec_ismem, dec_isstore, dec_legal;
  logic       is_mem_r, is_store_r;
  logic       retire;

  mips_alu_ctrl_decode u_decode (
    .opcode   (instrOut[31:26]),
    .funct    (instrOut[5:0]),
    .ALUCtrl  (dec_alu),
    .RegDst   (dec_regdst),
    .ALUSrc   (dec_alusrc),
    .MemtoReg (dec_memtoreg),
    .isMem    (dec_ismem),
    .isStore  (dec_isstore),
    .legal    (dec_legal)
  );

  always_comb begin
    next = state;
    unique case (state)
      IDLE:      if (instrValid) next = DECODE;
      DECODE:    next = dec_legal ? EXECUTE : IDLE;
      EXECUTE:   next = is_mem_r ? MEM : WRITEBACK;
      MEM:       next = is_store_r ? IDLE : WRITEBACK;
      WRITEBACK: next = IDLE;
      default:   next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instrOut <= '0;
    else if (state == IDLE && instrValid) instrOut <= instruction;
  end

  // Decoded controls are captured once in DECODE and cleared on any return to
  // IDLE, so an illegal encoding leaves them at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUCtrl    <= '0;
      RegDst     <= 1'b0;
      ALUSrc     <= 1'b0;
      MemtoReg   <= 1'b0;
      is_mem_r   <= 1'b0;
      is_store_r <= 1'b0;
    end else if (state == DECODE && dec_legal) begin
      ALUCtrl    <= dec_alu;
      RegDst     <= dec_regdst;
      ALUSrc     <= dec_alusrc;
      MemtoReg   <= dec_memtoreg;
      is_mem_r   <= dec_ismem;
      is_store_r <= dec_isstore;
    end else if (next == IDLE) begin
      ALUCtrl    <= '0;
      RegDst     <= 1'b0;
      ALUSrc     <= 1'b0;
      MemtoReg   <= 1'b0;
      is_mem_r   <= 1'b0;
      is_store_r <= 1'b0;
    end
  end

  assign retire = (state == WRITEBACK) || (state == MEM && is_store_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retiredCount <= '0;
    else if (retire) retiredCount <= retiredCount + COUNT_WIDTH'(1);
  end

  // Strobes decode straight from the state register so reset kills them at once.
  assign instrReady = (state == IDLE) && rst_n;
  assign illegal    = (state == DECODE) && !dec_legal;
  assign RegWrite   = (state == WRITEBACK);
  assign MemWrite   = (state == MEM) && is_store_r;
  assign MemRead    = (state == MEM || state == WRITEBACK) && is_mem_r && !is_store_r;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: stimulus pushes expected
// per-instruction behaviour, a negedge monitor pops and compares it.
module tb_mips_multicycle_control;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instrValid = 1'b0;
  logic [31:0]   instruction = '0;
  logic          instrReady;
  logic [31:0]   instrOut;
  logic          RegDst, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite, illegal;
  logic [3:0]    ALUCtrl;
  logic [CW-1:0] retiredCount;

  mips_multicycle_control #(.COUNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instrValid   (instrValid),
    .instruction  (instruction),
    .instrReady   (instrReady),
    .instrOut     (instrOut),
    .RegDst       (RegDst),
    .ALUSrc       (ALUSrc),
    .ALUCtrl      (ALUCtrl),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .MemtoReg     (MemtoReg),
    .RegWrite     (RegWrite),
    .illegal      (illegal),
    .retiredCount (retiredCount)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]   instr;
    bit            legal;
    logic [3:0]    alu;
    bit            regdst, alusrc, memtoreg;
    int            busy, mr, rw, mw, ill;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   model_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference behaviour straight from the instruction table and path lengths.
  function automatic exp_t model(input logic [31:0] w);
    exp_t       e;
    logic [5:0] op, fn;
    bit         is_lw, is_sw;
    op = w[31:26];
    fn = w[5:0];
    e.instr = w; e.legal = 1; e.alu = 4'h0;
    e.regdst = 1; e.alusrc = 1; e.memtoreg = 0;
    is_lw = 0; is_sw = 0;
    if (op == 6'h00) begin
      e.regdst = 0; e.alusrc = 0;
      case (fn)
        6'h24:   e.alu = 4'b0000;
        6'h25:   e.alu = 4'b0001;
        6'h20:   e.alu = 4'b0010;
        6'h22:   e.alu = 4'b0110;
        6'h2A:   e.alu = 4'b0111;
        6'h27:   e.alu = 4'b1100;
        default: e.legal = 0;
      endcase
    end else begin
      case (op)
        6'h08:   e.alu = 4'b0010;
        6'h0A:   e.alu = 4'b0111;
        6'h23:   begin e.alu = 4'b0010; e.memtoreg = 1; is_lw = 1; end
        6'h2B:   begin e.alu = 4'b0010; is_sw = 1; end
        default: e.legal = 0;
      endcase
    end
    if (!e.legal) begin
      e.regdst = 0; e.alusrc = 0;
    end
    // busy = cycles with instrReady low after the accept edge
    e.busy = !e.legal ? 1 : (is_lw ? 4 : 3);
    e.mr   = is_lw ? 2 : 0;
    e.rw   = (e.legal && !is_sw) ? 1 : 0;
    e.mw   = is_sw ? 1 : 0;
    e.ill  = e.legal ? 0 : 1;
    if (e.legal) model_count = (model_count + 1) % (1 << CW);
    e.cnt = CW'(model_count);
    return e;
  endfunction

  // Monitor
  bit   inflight = 0;
  bit   prev_ready = 0;
  exp_t cur;
  int   m_busy, m_mr, m_rw, m_mw, m_ill, m_both, m_badinstr, m_strobes;
  logic [3:0] c_alu;
  logic c_regdst, c_alusrc, c_memtoreg;

  always @(negedge clk) begin
    if (!rst_n) begin
      inflight   = 0;
      prev_ready = 0;
    end else begin
      if (!inflight && prev_ready && !instrReady) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_accept actual=busy required=idle (t=%0t)", $time);
        end else begin
          cur = exp_q.pop_front();
          inflight = 1;
          m_busy = 0; m_mr = 0; m_rw = 0; m_mw = 0; m_ill = 0;
          m_both = 0; m_badinstr = 0; m_strobes = 0;
          c_alu = '0; c_regdst = 0; c_alusrc = 0; c_memtoreg = 0;
        end
      end
      if (inflight && !instrReady) begin
        m_busy++;
        m_mr  += int'(MemRead);
        m_rw  += int'(RegWrite);
        m_mw  += int'(MemWrite);
        m_ill += int'(illegal);
        if (RegWrite && MemWrite) m_both++;
        if (instrOut !== cur.instr) m_badinstr++;
        if (RegWrite || MemWrite) begin
          m_strobes++;
          c_alu = ALUCtrl; c_regdst = RegDst; c_alusrc = ALUSrc; c_memtoreg = MemtoReg;
        end
      end else if (inflight && instrReady) begin
        chk("busy_cycles", m_busy, cur.busy);
        chk("memread_cycles", m_mr, cur.mr);
        chk("regwrite_pulses", m_rw, cur.rw);
        chk("memwrite_pulses", m_mw, cur.mw);
        chk("illegal_pulses", m_ill, cur.ill);
        chk("strobe_overlap", m_both, 0);
        chk("instrout_stable", m_badinstr, 0);
        if (cur.legal) begin
          chk("aluctrl", c_alu, cur.alu);
          chk("regdst", c_regdst, cur.regdst);
          chk("alusrc", c_alusrc, cur.alusrc);
          chk("memtoreg", c_memtoreg, cur.memtoreg);
        end
        chk("retired_count", retiredCount, cur.cnt);
        chk("idle_strobes", {illegal, MemRead, MemWrite, RegWrite}, 4'b0000);
        inflight = 0;
      end
      prev_ready = instrReady;
    end
  end

  int last_acc = 0;

  task automatic issue(input logic [31:0] w, input bit hold);
    int n;
    @(posedge clk); #1;
    instrValid = 1'b1;
    instruction = w;
    n = 0;
    do begin @(negedge clk); n++; end while (!instrReady && n < 40);
    if (!instrReady) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=not_ready required=ready (t=%0t)", $time);
      instrValid = 1'b0;
      return;
    end
    last_acc = cyc;
    exp_q.push_back(model(w));
    @(posedge clk); #1;
    if (!hold) instrValid = 1'b0;
    instruction = $urandom();
  endtask

  function automatic logic [31:0] gen();
    logic [31:0] w;
    logic [5:0]  fns[6];
    int          k;
    fns[0] = 6'h24; fns[1] = 6'h25; fns[2] = 6'h20;
    fns[3] = 6'h22; fns[4] = 6'h2A; fns[5] = 6'h27;
    w = $urandom();
    k = $urandom_range(0, 11);
    if (k <= 5)       w = {6'h00, w[25:6], fns[k]};
    else if (k == 6)  w[31:26] = 6'h08;
    else if (k == 7)  w[31:26] = 6'h0A;
    else if (k == 8)  w[31:26] = 6'h23;
    else if (k == 9)  w[31:26] = 6'h2B;
    else if (k == 10) w = {6'h00, w[25:6], 6'h21};
    return w;
  endfunction

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || inflight) && n < 100) begin
      @(negedge clk); n++;
    end
    if (exp_q.size() != 0 || inflight) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0 (t=%0t)", exp_q.size(), $time);
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_ready"}, instrReady, 1'b0);
    chk({name, "_instrout"}, instrOut, 32'h0);
    chk({name, "_ctrl"}, {RegDst, ALUSrc, ALUCtrl, MemtoReg}, 7'h0);
    chk({name, "_strobes"}, {MemRead, MemWrite, RegWrite, illegal}, 4'h0);
    chk({name, "_count"}, retiredCount, 0);
  endtask

  initial begin
    int n;
    int prev_acc;

    // Power-on reset held for 3 cycles
    repeat (3) begin
      @(negedge clk);
      check_all_zero("reset");
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", instrReady, 1'b1);
    chk("count_after_reset", retiredCount, 0);

    // Directed: add, slt, lw, sw, j, R-type funct 0x21
    issue(32'h00221820, 0);
    issue(32'h0022182A, 0);
    issue(32'h8C220004, 0);
    issue(32'hAC220008, 0);
    issue(32'h08000000, 0);
    issue(32'h00221821, 0);
    drain();
    chk("directed_count", retiredCount, 4);

    // Randomized mix with random gaps and valid held high while busy
    for (int i = 0; i < 120; i++) begin
      bit hold;
      hold = 1'($urandom_range(0, 1));
      issue(gen(), hold);
      if (!hold) repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    #1 instrValid = 1'b0;
    drain();

    // Reset while an lw sits in MEM
    issue(32'h8C220004, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!MemRead && n < 10);
    chk("lw_reaches_mem", MemRead, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    exp_q.delete();
    model_count = 0;
    repeat (2) begin
      @(negedge clk);
      chk("midreset_no_regwrite", {RegWrite, MemWrite}, 2'b00);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_ready", instrReady, 1'b1);
    chk("midreset_count", retiredCount, 0);
    chk("midreset_no_regwrite_after", RegWrite, 1'b0);

    // Back-to-back addi through a full counter wrap
    prev_acc = 0;
    for (int i = 0; i < (1 << CW); i++) begin
      issue({6'h08, 5'd1, 5'd2, 16'(i)}, 1);
      if (i > 0 && (i % 16 == 1)) chk("accept_spacing", last_acc - prev_acc, 4);
      prev_acc = last_acc;
    end
    #1 instrValid = 1'b0;
    drain();
    chk("wrap_count", retiredCount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
